operand_sequencer: RTL

Controller that sequences the CPU's operand memory and a small integer execute stage. When `start` is accepted, it:

- issues CLEAR, then two LOAD commands on `tx`;
- captures the two returned operands into `reg_a` and `reg_b`;
- executes the latched opcode and pulses `done`.

It sits between the top-level control and the operand memory, and is the only driver of the memory's `tx` command input.

---
 rtl/operand_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: drives CLEAR/LOAD/LOAD to the operand memory, captures two operands,
// then runs a 2-bit-opcode add/sub/and/or on them and pulses done.
module operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    output logic [3:0]       tx,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy,
    output logic             done,
    output logic [3:0]       current_state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        CLR  = 4'd1,
        LD_A = 4'd2,
        LD_B = 4'd3,
        CAPT = 4'd4,
        EXEC = 4'd5,
        DONE = 4'd6
    } state_t;

    localparam logic [3:0] TX_CLEAR = 4'd0;
    localparam logic [3:0] TX_LOAD  = 4'd1;
    localparam logic [3:0] TX_HOLD  = 4'd2;

    state_t         state, state_next;
    logic [1:0]     op;
    logic [WIDTH:0] alu;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op     <= 2'b00;
            reg_a  <= '0;
            reg_b  <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) op <= opcode;
            if (state == LD_B) reg_a <= entrada;
            if (state == CAPT) reg_b <= entrada;
            if (state == EXEC) {carry, result} <= alu;
        end
    end

    // The extra top bit is the add carry-out, and for subtraction the borrow (a < b).
    always_comb begin
        alu = op == 2'b00 ? {1'b0, reg_a} + {1'b0, reg_b} :
              op == 2'b01 ? {1'b0, reg_a} - {1'b0, reg_b} :
              op == 2'b10 ? {1'b0, reg_a & reg_b} :
                            {1'b0, reg_a | reg_b};
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? CLR : IDLE;
            CLR:     state_next = LD_A;
            LD_A:    state_next = LD_B;
            LD_B:    state_next = CAPT;
            CAPT:    state_next = EXEC;
            EXEC:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign tx            = state == CLR ? TX_CLEAR : (state == LD_A || state == LD_B) ? TX_LOAD : TX_HOLD;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign current_state = state;
endmodule
